ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_pkg.sv | 33 +++
 rtl/ifetch_buf.sv | 55 +++++
 rtl/ifetch_unit.sv | 126 ++++++++++++
 tb/tb_ifetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: IFETCH_JUMP_PREDECODE_EN (see ifetch_unit).
package ifetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DISCARD
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  function automatic logic [31:0] jtarget(
    input logic [3:0]  hi,
    input logic [25:0] idx
  );
    return {hi, idx, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry FIFO of fetch entries with flush.
// Push and pop in the same cycle are both honoured, even when full.
module ifetch_buf
  import ifetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  fetch_t     din,
  input  logic       pop,
  input  logic       flush,
  output fetch_t     dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  fetch_t     mem [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;
  logic       do_push;
  logic       do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign count   = cnt_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (flush) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_q] <= din;
        wr_q      <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding imem request, 2-entry buffer.
// Define IFETCH_JUMP_PREDECODE_EN to follow J instructions at fetch.
module ifetch_unit
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  op,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] pc_adv;
  logic [31:0] addr_q;

  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [1:0]  count;
  logic [1:0]  cnt_next;
  fetch_t      din;
  fetch_t      dout;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef IFETCH_JUMP_PREDECODE_EN
  assign pc_adv = (imem_rdata[31:26] == OP_J)
                ? jtarget(pc_plus4[31:28], imem_rdata[25:0])
                : pc_plus4;
`else
  assign pc_adv = pc_plus4;
`endif

  assign push = (state_q == S_REQ) && imem_ack && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign din  = '{pc: pc_q, instr: imem_rdata};

  assign cnt_next = count + {1'b0, push} - {1'b0, pop};

  ifetch_buf u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (din),
    .pop     (pop),
    .flush   (redirect_valid),
    .dout    (dout),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == S_REQ && state_d == S_DISCARD) begin
        addr_q <= pc_q;
      end
    end
  end

  // Occupancy plus the in-flight word must never exceed the buffer depth.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          state_d = imem_ack ? S_REQ : S_DISCARD;
        end else if (imem_ack) begin
          state_d = cnt_next[1] ? S_WAIT : S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect_valid || !full || pop) begin
          state_d = S_REQ;
        end
      end
      S_DISCARD: begin
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redirect_valid: pc_d = {redirect_pc[31:2], 2'b00};
      push:           pc_d = pc_adv;
      default:        pc_d = pc_q;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == S_REQ) || (state_q == S_DISCARD);
    imem_addr = (state_q == S_DISCARD) ? {addr_q[31:2], 2'b00}
                                       : {pc_q[31:2], 2'b00};
  end

  assign instr_valid = !empty;
  assign instr       = dout.instr;
  assign instr_pc    = dout.pc;
  assign op          = dout.instr[31:26];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: streaming, stall, redirects, wrap, jump.
// Behavioural memory acks combinationally while ack_en is set.
module tb_ifetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  op;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        ack_en;
  logic        jmp_on;
  logic [31:0] jmp_addr;
  logic [31:0] jmp_word;
  int          vecs = 0;
  int          errs = 0;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return {6'b001000, a[27:2]};
  endfunction

  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = (jmp_on && imem_addr == jmp_addr) ? jmp_word
                                                        : dat(imem_addr);

  ifetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op             (op),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic ack);
    reset_n = 1'b0;
    ack_en  = ack;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    vecs++;
    if (imem_req !== 1'b0) begin
      errs++;
      $display("FAIL rst_req: got %b want 0", imem_req);
    end
    vecs++;
    if (imem_addr !== 32'h0) begin
      errs++;
      $display("FAIL rst_addr: got %h want 0", imem_addr);
    end
    vecs++;
    if (instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_valid: got %b want 0", instr_valid);
    end
    vecs++;
    if (instr !== 32'h0 || instr_pc !== 32'h0 || op !== 6'h0) begin
      errs++;
      $display("FAIL rst_instr: got %h/%h/%h want 0", instr, instr_pc, op);
    end
  endtask

  task automatic test_stream();
    instr_ready = 1'b1;
    restart(1'b1);
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL stream_first: req %b addr %h valid %b want 1 0 0",
               imem_req, imem_addr, instr_valid);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      vecs++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k)
          || instr !== dat(32'(4 * k))) begin
        errs++;
        $display("FAIL stream_%0d: valid %b pc %h instr %h want 1 %h %h",
                 k, instr_valid, instr_pc, instr, 4 * k, dat(32'(4 * k)));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] p;
    p = instr_pc;
    instr_ready = 1'b0;
    repeat (5) tick();
    vecs++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== p) begin
      errs++;
      $display("FAIL stall_hold: req %b valid %b pc %h want 0 1 %h",
               imem_req, instr_valid, instr_pc, p);
    end
    instr_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vecs++;
      if (instr_valid !== 1'b1 || instr_pc !== p + 32'(4 * k)) begin
        errs++;
        $display("FAIL drain_%0d: valid %b pc %h want 1 %h",
                 k, instr_valid, instr_pc, p + 32'(4 * k));
      end
    end
  endtask

  task automatic test_same_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h83;
    tick();
    redirect_valid = 1'b0;
    vecs++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h80 || imem_req !== 1'b1) begin
      errs++;
      $display("FAIL redir_ack: valid %b addr %h req %b want 0 80 1",
               instr_valid, imem_addr, imem_req);
    end
    tick();
    vecs++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h80 || instr !== dat(32'h80)) begin
      errs++;
      $display("FAIL redir_word: valid %b pc %h instr %h want 1 80 %h",
               instr_valid, instr_pc, instr, dat(32'h80));
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    vecs++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errs++;
      $display("FAIL wrap_top: got %h want fffffffc", imem_addr);
    end
    tick();
    vecs++;
    if (imem_addr !== 32'h0 || instr_pc !== 32'hFFFF_FFFC) begin
      errs++;
      $display("FAIL wrap: addr %h pc %h want 0 fffffffc", imem_addr, instr_pc);
    end
  endtask

  task automatic test_jump();
    logic [31:0] want;
`ifdef IFETCH_JUMP_PREDECODE_EN
    want = 32'h40;
`else
    want = 32'h104;
`endif
    jmp_on         = 1'b1;
    jmp_addr       = 32'h100;
    jmp_word       = 32'h0800_0010;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    vecs++;
    if (imem_addr !== 32'h100) begin
      errs++;
      $display("FAIL jump_fetch: got %h want 100", imem_addr);
    end
    tick();
    vecs++;
    if (instr_pc !== 32'h100 || op !== 6'h02 || imem_addr !== want) begin
      errs++;
      $display("FAIL jump_next: pc %h op %h addr %h want 100 02 %h",
               instr_pc, op, imem_addr, want);
    end
    jmp_on = 1'b0;
  endtask

  task automatic test_discard();
    reset_n = 1'b0;
    #1;
    vecs++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      errs++;
      $display("FAIL async_rst: valid %b req %b want 0 0", instr_valid, imem_req);
    end
    restart(1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_valid = 1'b0;
    ack_en         = 1'b1;
    tick();
    ack_en = 1'b0;
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errs++;
      $display("FAIL disc_setup: req %b addr %h want 1 10", imem_req, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin
        errs++;
        $display("FAIL disc_hold_%0d: req %b addr %h valid %b want 1 10 0",
                 k, imem_req, imem_addr, instr_valid);
      end
      if (k == 2) ack_en = 1'b1;
      tick();
    end
    vecs++;
    if (imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL disc_drop: addr %h valid %b want 40 0", imem_addr, instr_valid);
    end
    tick();
    vecs++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
      errs++;
      $display("FAIL disc_new: valid %b pc %h want 1 40", instr_valid, instr_pc);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ack_en         = 1'b0;
    jmp_on         = 1'b0;
    jmp_addr       = 32'h0;
    jmp_word       = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_same_cycle();
    test_wrap();
    test_jump();
    test_discard();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
